// File: rtl/quad_debounce_pkg.sv
// quad_debounce_pkg: shared debounce defaults and channel indices.
package quad_debounce_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STABLE_CNT_DEF  = 50000;
  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: synchronizer, stability counter and output flop for one raw input.
// Edge pulse outputs exist only when QUAD_DEBOUNCE_EDGE_EN is defined.
module debounce_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4,
  parameter int CNT_W       = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_idle
`ifdef QUAD_DEBOUNCE_EDGE_EN
  ,
  output logic o_rise,
  output logic o_fall
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt;
  logic s, accept;
  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != o_level) && (cnt == LAST);
  assign o_idle = (cnt == '0) && (s == o_level);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync_q  <= '0;
      cnt     <= '0;
      o_level <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
      // an agreeing sample or an accepted change both restart the count
      cnt    <= (s == o_level || accept) ? '0 : cnt + 1'b1;
      if (accept) o_level <= s;
    end
`ifdef QUAD_DEBOUNCE_EDGE_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= accept & s;
      o_fall <= accept & ~s;
    end
`endif
endmodule

// File: rtl/quad_input_debouncer.sv
// quad_input_debouncer: four independent debounced channels plus an all-settled flag.
// Define QUAD_DEBOUNCE_EDGE_EN to add registered o_rise/o_fall pulse outputs.
module quad_input_debouncer
  import quad_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STABLE_CNT  = STABLE_CNT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_a_raw,
  input  logic       i_b_raw,
  input  logic       i_c_raw,
  input  logic       i_d_raw,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d,
  output logic       o_stable
`ifdef QUAD_DEBOUNCE_EDGE_EN
  ,
  output logic [3:0] o_rise,
  output logic [3:0] o_fall
`endif
);
  if (STABLE_CNT < 1 || SYNC_STAGES < 2 || (STABLE_CNT - 1) >= (2 ** CNT_W))
    $error("quad_input_debouncer: illegal SYNC_STAGES/STABLE_CNT/CNT_W");
  logic [3:0] raw, level, idle;
  assign raw = {i_d_raw, i_c_raw, i_b_raw, i_a_raw};
  for (genvar i = 0; i < 4; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT),
      .CNT_W      (CNT_W)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_raw  (raw[i]),
      .o_level(level[i]),
      .o_idle (idle[i])
`ifdef QUAD_DEBOUNCE_EDGE_EN
      ,
      .o_rise (o_rise[i]),
      .o_fall (o_fall[i])
`endif
    );
  end
  assign o_a      = level[CH_A];
  assign o_b      = level[CH_B];
  assign o_c      = level[CH_C];
  assign o_d      = level[CH_D];
  assign o_stable = &idle;
endmodule

// File: tb/tb_quad_input_debouncer.sv
// tb_quad_input_debouncer: directed vectors with a queued scoreboard, SYNC_STAGES=2, STABLE_CNT=4.
module tb_quad_input_debouncer;
  typedef struct packed {
    logic [3:0] lvl;
    logic       stb;
    logic [3:0] r;
    logic [3:0] f;
  } exp_t;

  logic i_clk = 1'b0, i_rst_n = 1'b0;
  logic [3:0] raw_v = 4'h0;
  logic o_a, o_b, o_c, o_d, o_stable;
  logic [3:0] rise_v, fall_v;
  exp_t q[$];
  event async_ev;
  int checks = 0, errors = 0;

`ifdef QUAD_DEBOUNCE_EDGE_EN
  logic [3:0] o_rise, o_fall;
  assign rise_v = o_rise;
  assign fall_v = o_fall;
`else
  assign rise_v = 4'h0;
  assign fall_v = 4'h0;
`endif

  quad_input_debouncer #(.SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(3)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_a_raw (raw_v[0]),
    .i_b_raw (raw_v[1]),
    .i_c_raw (raw_v[2]),
    .i_d_raw (raw_v[3]),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_c     (o_c),
    .o_d     (o_d),
    .o_stable(o_stable)
`ifdef QUAD_DEBOUNCE_EDGE_EN
    ,
    .o_rise  (o_rise),
    .o_fall  (o_fall)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  // monitor: pops one expectation per negedge (or on an async-reset probe)
  initial forever begin
    @(negedge i_clk or async_ev);
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("levels", {o_d, o_c, o_b, o_a}, e.lvl);
      cmp("stable", {3'b0, o_stable}, {3'b0, e.stb});
`ifdef QUAD_DEBOUNCE_EDGE_EN
      cmp("rise", rise_v, e.r);
      cmp("fall", fall_v, e.f);
`endif
    end
  end

  task automatic step(input logic [3:0] raw, input logic [3:0] lvl, input logic stb,
                      input logic [3:0] r, input logic [3:0] f);
    raw_v = raw;
    @(posedge i_clk);
    q.push_back('{lvl, stb, r, f});
    @(negedge i_clk);
  endtask

  // raw change sampled on edge 1: pending from edge 2, output and pulse on edge 6
  task automatic transition(input logic [3:0] raw, input logic [3:0] old_l,
                            input logic [3:0] new_l, input logic [3:0] r, input logic [3:0] f);
    step(raw, old_l, 1'b1, 4'h0, 4'h0);
    repeat (4) step(raw, old_l, 1'b0, 4'h0, 4'h0);
    step(raw, new_l, 1'b1, r, f);
    step(raw, new_l, 1'b1, 4'h0, 4'h0);
  endtask

  initial begin
    @(negedge i_clk);
    repeat (3) step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0);
    i_rst_n = 1'b1;
    repeat (3) step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0);
    transition(4'h1, 4'h0, 4'h1, 4'h1, 4'h0);
    transition(4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
    // b pulse of 3 samples reaches cnt=3 but is cleared before acceptance
    step(4'h2, 4'h0, 1'b1, 4'h0, 4'h0);
    step(4'h2, 4'h0, 1'b0, 4'h0, 4'h0);
    step(4'h2, 4'h0, 1'b0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b1, 4'h0, 4'h0);
    transition(4'hF, 4'h0, 4'hF, 4'hF, 4'h0);
    transition(4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
    // c bounce 1,1,0,1,1,...: accepted on edge 9
    step(4'h4, 4'h0, 1'b1, 4'h0, 4'h0);
    step(4'h4, 4'h0, 1'b0, 4'h0, 4'h0);
    step(4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    for (int k = 4; k <= 8; k++) step(4'h4, 4'h0, 1'b0, 4'h0, 4'h0);
    step(4'h4, 4'h4, 1'b1, 4'h4, 4'h0);
    step(4'h4, 4'h4, 1'b1, 4'h0, 4'h0);
    transition(4'h0, 4'h4, 4'h0, 4'h0, 4'h4);
    // a settles high, then d starts counting and reset hits at cnt=2
    transition(4'h1, 4'h0, 4'h1, 4'h1, 4'h0);
    step(4'h9, 4'h1, 1'b1, 4'h0, 4'h0);
    step(4'h9, 4'h1, 1'b0, 4'h0, 4'h0);
    step(4'h9, 4'h1, 1'b0, 4'h0, 4'h0);
    step(4'h9, 4'h1, 1'b0, 4'h0, 4'h0);
    #2 i_rst_n = 1'b0;
    #1 q.push_back('{4'h0, 1'b1, 4'h0, 4'h0});
    ->async_ev;
    @(negedge i_clk);
    repeat (2) step(4'h9, 4'h0, 1'b1, 4'h0, 4'h0);
    i_rst_n = 1'b1;
    transition(4'h9, 4'h0, 4'h9, 4'h9, 4'h0);
    repeat (2) step(4'h9, 4'h9, 1'b1, 4'h0, 4'h0);
    @(negedge i_clk);
    cmp("queue_drained", 4'(q.size()), 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
